// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, co, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, co, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, co);
    modport slave  (input start, a, b, cin, output busy, done, sum, co);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fullAdder bit per clock, LSB first, carry held in a flop.
// Optional signed overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ cin;
    assign co  = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ps_q, ps_d, sum_q, sum_d;
    logic             c_q, c_d, co_q, co_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             fa_sum, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fullAdder fa (
        .a   (sa_q[0]),
        .b   (sb_q[0]),
        .cin (c_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ps_d  = {fa_sum, ps_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = fa_co;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = {fa_sum, ps_q[WIDTH-1:1]};
                    co_d    = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q is the carry into the MSB on this last bit
                    ovf_d   = c_q ^ fa_co;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flops track the next state so busy/done come straight from registers
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8); ovf vectors apply when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic [W-1:0] es, input logic eco);
        int lat;
        lat = 0;
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = ci;
        tick();
        bus.start = 1'b0;
        chk({tag, ".busy_rise"}, bus.busy, 1);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (bus.done) lat = i;
        end
        chk({tag, ".latency"}, lat, W);
        chk({tag, ".sum"}, bus.sum, es);
        chk({tag, ".co"}, bus.co, eco);
        chk({tag, ".busy_done"}, bus.busy, 1);
        tick();
        chk({tag, ".done_fall"}, bus.done, 0);
        chk({tag, ".busy_fall"}, bus.busy, 0);
    endtask

    initial begin
        int ndone, d1, d2;
        logic [W-1:0] s1, s2;
        logic c1, c2;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        tick(); tick();
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.sum", bus.sum, 0);
        chk("rst.co", bus.co, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst.ovf", bus.ovf, 0);
`endif
        reset_n = 1'b1;
        tick();

        op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op("addff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

        // Second start mid-operation must be ignored
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        chk("hold.sum", bus.sum, 8'h00);
        chk("hold.co", bus.co, 1);
        tick();
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'hAA;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        chk("ign.ndone", ndone, 1);
        chk("ign.sum", bus.sum, 8'h30);
        chk("ign.co", bus.co, 0);

        // Asynchronous reset mid-operation
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("abort.busy", bus.busy, 0);
        chk("abort.done", bus.done, 0);
        chk("abort.sum", bus.sum, 0);
        chk("abort.co", bus.co, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        op("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Back-to-back with start held high
        bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0;
        tick();
        bus.a = 8'h0F; bus.b = 8'hF1;
        d1 = -1; d2 = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (bus.done) begin
                if (d1 < 0) begin d1 = i; s1 = bus.sum; c1 = bus.co; end
                else begin d2 = i; s2 = bus.sum; c2 = bus.co; end
            end
        end
        bus.start = 1'b0;
        chk("b2b.first_lat", d1, W);
        chk("b2b.sum1", s1, 8'h00);
        chk("b2b.co1", c1, 1);
        chk("b2b.spacing", d2 - d1, W + 2);
        chk("b2b.sum2", s2, 8'h00);
        chk("b2b.co2", c2, 1);
        repeat (12) tick();

`ifdef SERIAL_ADDER_OVF_EN
        op("ovf7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        chk("ovf7f01.ovf", bus.ovf, 1);
        op("ovfff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        chk("ovfff01.ovf", bus.ovf, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
